// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Chooses the PC source and the IF/ID and ID/EX write/flush controls each cycle.
// Inputs are branch resolution in EX, jumps in ID, load-use hazards and the
// mult/div HI/LO interlock. It also keeps saturating stall and redirect counters.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16,
  parameter int REG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_branch_taken,
  input  logic             id_is_jump,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_muldiv_start,
  input  logic             id_hilo_dep,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MDW = $clog2(MD_LAT + 1);
  localparam logic [MDW-1:0] MD_LAT_V    = MDW'(MD_LAT);
  localparam logic [MDW-1:0] MD_LAT_M1   = MDW'(MD_LAT - 1);
  localparam logic [MDW-1:0] MD_ONE      = MDW'(1);
  localparam logic [1:0]     SEL_SEQ     = 2'd0;
  localparam logic [1:0]     SEL_BRANCH  = 2'd1;
  localparam logic [1:0]     SEL_JUMP    = 2'd2;

  logic [MDW-1:0] md_cnt;
  logic [MDW-1:0] r_eff;
  logic           load_use;
  logic           md_stall;
  logic           stall_evt;
  logic           flush_evt;

  // Hazard detection: load-use match and cycles left before HI/LO is usable.
  // A mult/div issuing this cycle counts as the full latency still remaining.
  always_comb begin
    load_use = ex_mem_read && (ex_rt != '0) &&
               ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    r_eff    = ex_muldiv_start ? MD_LAT_V : md_cnt;
    md_stall = id_hilo_dep && (r_eff > MD_ONE);
  end

  // Prioritised control decode: reset, taken branch, stall, jump, then sequential.
  // A stalled jump stays in ID, so it redirects on its first unstalled cycle.
  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = SEL_SEQ;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel      = SEL_BRANCH;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_evt   = 1'b1;
    end else if (load_use || md_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      stall_evt   = 1'b1;
    end else if (id_is_jump) begin
      pc_sel      = SEL_JUMP;
      if_id_flush = 1'b1;
      flush_evt   = 1'b1;
    end
  end

  // Mult/div countdown: reloads on issue and keeps running through stalls and flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (ex_muldiv_start) begin
      md_cnt <= MD_LAT_M1;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_ONE;
    end
  end

  // Performance counters: at most one increment per cycle, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Two instances share one input stream: MD_LAT=4/CNT_W=4 and MD_LAT=1/CNT_W=16.
// A time-based reference model pushes expected responses into a queue.
// A monitor pops each entry and compares it against the DUT outputs.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       reset;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       md_start;
    logic       hilo_dep;
  } stim_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
  } ctrl_t;

  typedef struct {
    int    cycle;
    ctrl_t c4;
    ctrl_t c1;
    int    sc4;
    int    fc4;
    int    sc1;
    int    fc1;
  } exp_t;

  logic clk = 1'b0;
  stim_t cur;

  logic        pc_write4, if_id_write4, if_id_flush4, id_ex_flush4;
  logic [1:0]  pc_sel4;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic        pc_write1, if_id_write1, if_id_flush1, id_ex_flush1;
  logic [1:0]  pc_sel1;
  logic [15:0] stall_cnt1, flush_cnt1;

  exp_t scoreboard[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;

  int now = 0;
  int ready4 = 0;
  int ready1 = 0;
  int sc4 = 0, fc4 = 0, sc1 = 0, fc1 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4), .REG_W(5)) dut4 (
    .clk(clk), .reset(cur.reset), .ex_branch_taken(cur.branch), .id_is_jump(cur.jump),
    .ex_mem_read(cur.mem_read), .ex_rt(cur.ex_rt), .id_rs(cur.id_rs), .id_rt(cur.id_rt),
    .id_uses_rs(cur.uses_rs), .id_uses_rt(cur.uses_rt), .ex_muldiv_start(cur.md_start),
    .id_hilo_dep(cur.hilo_dep), .pc_write(pc_write4), .pc_sel(pc_sel4),
    .if_id_write(if_id_write4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  hazard_ctrl #(.MD_LAT(1), .CNT_W(16), .REG_W(5)) dut1 (
    .clk(clk), .reset(cur.reset), .ex_branch_taken(cur.branch), .id_is_jump(cur.jump),
    .ex_mem_read(cur.mem_read), .ex_rt(cur.ex_rt), .id_rs(cur.id_rs), .id_rt(cur.id_rt),
    .id_uses_rs(cur.uses_rs), .id_uses_rt(cur.uses_rt), .ex_muldiv_start(cur.md_start),
    .id_hilo_dep(cur.hilo_dep), .pc_write(pc_write1), .pc_sel(pc_sel1),
    .if_id_write(if_id_write1), .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  // Reference decision for one cycle given whether HI/LO is still busy.
  function automatic ctrl_t refCtrl(input stim_t s, input bit hiloBusy);
    ctrl_t c;
    bit loadUse;
    loadUse = s.mem_read && (s.ex_rt != 5'd0) &&
              ((s.uses_rs && s.id_rs == s.ex_rt) || (s.uses_rt && s.id_rt == s.ex_rt));
    c.pc_write = 1'b1; c.pc_sel = 2'd0; c.if_id_write = 1'b1;
    c.if_id_flush = 1'b0; c.id_ex_flush = 1'b0;
    if (s.reset) begin
      c.pc_write = 1'b0; c.if_id_write = 1'b0; c.if_id_flush = 1'b1; c.id_ex_flush = 1'b1;
    end else if (s.branch) begin
      c.pc_sel = 2'd1; c.if_id_flush = 1'b1; c.id_ex_flush = 1'b1;
    end else if (loadUse || (s.hilo_dep && hiloBusy)) begin
      c.pc_write = 1'b0; c.if_id_write = 1'b0; c.id_ex_flush = 1'b1;
    end else if (s.jump) begin
      c.pc_sel = 2'd2; c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

  function automatic int satInc(input int v, input bit inc, input int maxv);
    return (inc && v < maxv) ? v + 1 : v;
  endfunction

  // Drive one cycle of inputs, push the expected response, then advance the model.
  // HI/LO issued at cycle c is usable in EX at c+lat, so ID must wait while now < c+lat-1.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int lim4, lim1;
    @(posedge clk);
    #1;
    cur = s;
    lim4 = s.md_start ? now + 4 - 1 : ready4;
    lim1 = s.md_start ? now + 1 - 1 : ready1;
    e.cycle = now;
    e.c4 = refCtrl(s, now < lim4);
    e.c1 = refCtrl(s, now < lim1);
    e.sc4 = sc4; e.fc4 = fc4; e.sc1 = sc1; e.fc1 = fc1;
    scoreboard.push_back(e);
    if (s.reset) begin
      sc4 = 0; fc4 = 0; sc1 = 0; fc1 = 0; ready4 = 0; ready1 = 0;
    end else begin
      sc4 = satInc(sc4, !e.c4.pc_write, 15);
      fc4 = satInc(fc4, e.c4.pc_sel != 2'd0, 15);
      sc1 = satInc(sc1, !e.c1.pc_write, 65535);
      fc1 = satInc(fc1, e.c1.pc_sel != 2'd0, 65535);
      if (s.md_start) begin
        ready4 = lim4;
        ready1 = lim1;
      end
    end
    now++;
  endtask

  task automatic checkOutput(input string name, input int cyc, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else begin
      failCount++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Monitor: every cycle the DUTs present a response, compare it with the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput("pc_write4",    e.cycle, int'(pc_write4),    int'(e.c4.pc_write));
        checkOutput("pc_sel4",      e.cycle, int'(pc_sel4),      int'(e.c4.pc_sel));
        checkOutput("if_id_write4", e.cycle, int'(if_id_write4), int'(e.c4.if_id_write));
        checkOutput("if_id_flush4", e.cycle, int'(if_id_flush4), int'(e.c4.if_id_flush));
        checkOutput("id_ex_flush4", e.cycle, int'(id_ex_flush4), int'(e.c4.id_ex_flush));
        checkOutput("stall_cnt4",   e.cycle, int'(stall_cnt4),   e.sc4);
        checkOutput("flush_cnt4",   e.cycle, int'(flush_cnt4),   e.fc4);
        checkOutput("pc_write1",    e.cycle, int'(pc_write1),    int'(e.c1.pc_write));
        checkOutput("pc_sel1",      e.cycle, int'(pc_sel1),      int'(e.c1.pc_sel));
        checkOutput("if_id_write1", e.cycle, int'(if_id_write1), int'(e.c1.if_id_write));
        checkOutput("if_id_flush1", e.cycle, int'(if_id_flush1), int'(e.c1.if_id_flush));
        checkOutput("id_ex_flush1", e.cycle, int'(id_ex_flush1), int'(e.c1.id_ex_flush));
        checkOutput("stall_cnt1",   e.cycle, int'(stall_cnt1),   e.sc1);
        checkOutput("flush_cnt1",   e.cycle, int'(flush_cnt1),   e.fc1);
      end
    end
  end

  function automatic logic [4:0] pickReg();
    int p;
    p = $urandom_range(0, 2);
    return (p == 0) ? 5'd0 : ((p == 1) ? 5'd8 : 5'd9);
  endfunction

  // Stimulus: directed scenarios first, then a biased random stream.
  initial begin
    stim_t s;
    cur = '0;
    cur.reset = 1'b1;

    s = '0; s.reset = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    s = '0; applyStimulus(s);

    // Load of r8 in EX, add reading r8 in ID.
    s = '0; s.mem_read = 1'b1; s.ex_rt = 5'd8; s.id_rs = 5'd8; s.uses_rs = 1'b1;
    applyStimulus(s);
    s = '0; applyStimulus(s);

    // Load to r0 never interlocks.
    s = '0; s.mem_read = 1'b1; s.uses_rs = 1'b1;
    applyStimulus(s);

    // Taken branch beats a simultaneous load-use.
    s = '0; s.branch = 1'b1; s.mem_read = 1'b1; s.ex_rt = 5'd9; s.id_rt = 5'd9; s.uses_rt = 1'b1;
    applyStimulus(s);

    // mult in EX, then mfhi waiting in ID.
    s = '0; s.md_start = 1'b1; applyStimulus(s);
    s = '0; s.hilo_dep = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s = '0; applyStimulus(s);

    // Jump held in ID behind the HI/LO interlock.
    s = '0; s.md_start = 1'b1; s.jump = 1'b1; s.hilo_dep = 1'b1; applyStimulus(s);
    s.md_start = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s = '0; applyStimulus(s);

    // Long forced stall drives the 4-bit stall counter into saturation.
    s = '0; s.mem_read = 1'b1; s.ex_rt = 5'd8; s.id_rs = 5'd8; s.uses_rs = 1'b1;
    for (int i = 0; i < 19; i++) applyStimulus(s);
    s = '0; applyStimulus(s);

    // Reset while the countdown is mid-flight, then mfhi in ID.
    s = '0; s.md_start = 1'b1; applyStimulus(s);
    s = '0; applyStimulus(s);
    s = '0; s.reset = 1'b1; applyStimulus(s);
    s = '0; s.hilo_dep = 1'b1; applyStimulus(s);
    s = '0; applyStimulus(s);

    for (int n = 0; n < 600; n++) begin
      s = '0;
      s.reset    = ($urandom_range(0, 49) == 0);
      s.branch   = ($urandom_range(0, 7) == 0);
      s.md_start = !s.branch && ($urandom_range(0, 5) == 0);
      s.jump     = ($urandom_range(0, 4) == 0);
      s.mem_read = ($urandom_range(0, 2) == 0);
      s.ex_rt    = pickReg();
      s.id_rs    = pickReg();
      s.id_rt    = pickReg();
      s.uses_rs  = 1'($urandom_range(0, 1));
      s.uses_rt  = 1'($urandom_range(0, 1));
      s.hilo_dep = ($urandom_range(0, 2) == 0);
      applyStimulus(s);
    end

    for (int i = 0; i < 5 && scoreboard.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (scoreboard.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", scoreboard.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
